// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write integer register file with hard-wired
// zero register, writeback-to-read bypass and a per-register pending
// scoreboard that drives operand hazard and issue-ready outputs.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  ISSUE_VALID,
    input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
    output logic                  ISSUE_READY,
    output logic                  BUSY1,
    output logic                  BUSY2,
    input  logic                  FLUSH,
    output logic [ADDR_WIDTH:0]   PEND_CNT
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [ADDR_WIDTH:0]   cnt_q;

    logic wr_ok, issue_set, inc, dec;
    logic waw_haz;

    // Address exists in the array.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Address holds real state: in range and not the hard-wired zero.
    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) && !(ZERO_REG && (a == '0));
    endfunction

    // Pending lookup that tolerates out-of-range addresses.
    function automatic logic pend_at(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) ? pend[a] : 1'b0;
    endfunction

    // Read mux: zero/out-of-range first, then bypass, then storage.
    function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [ADDR_WIDTH-1:0] a);
        if (!writable(a))
            return '0;
        else if (BYPASS && wr_ok && (WA == a))
            return WD;
        else
            return mem[a];
    endfunction

    // Combinational read ports, hazards and issue handshake.
    always_comb begin
        wr_ok       = WE && writable(WA);
        RD1         = rd_port(RA1);
        RD2         = rd_port(RA2);
        BUSY1       = pend_at(RA1) && !(BYPASS && WE && (WA == RA1));
        BUSY2       = pend_at(RA2) && !(BYPASS && WE && (WA == RA2));
        // A writeback retiring the old writer in this cycle lifts the WAW block.
        waw_haz     = pend_at(ISSUE_RD) && !(WE && (WA == ISSUE_RD));
        ISSUE_READY = !BUSY1 && !BUSY2 && !waw_haz && !FLUSH;
        issue_set   = ISSUE_VALID && ISSUE_READY && writable(ISSUE_RD);
        // Same-register issue+writeback leaves the bit set: neither counts.
        inc         = issue_set && !pend_at(ISSUE_RD);
        dec         = WE && pend_at(WA) && !(issue_set && (ISSUE_RD == WA));
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] IDX = gi[ADDR_WIDTH-1:0];

            // Storage word: written on a qualified writeback hit.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST)
                    mem[gi] <= '0;
                else if (wr_ok && (WA == IDX))
                    mem[gi] <= WD;
            end

            // Pending bit: flush clears, issue sets, writeback clears; set wins.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST)
                    pend[gi] <= 1'b0;
                else if (FLUSH)
                    pend[gi] <= 1'b0;
                else if (issue_set && (ISSUE_RD == IDX))
                    pend[gi] <= 1'b1;
                else if (WE && (WA == IDX))
                    pend[gi] <= 1'b0;
            end
        end
    endgenerate

    // Pending count tracks the popcount incrementally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt_q <= '0;
        else if (FLUSH)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end

    assign PEND_CNT = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, write/read, zero register,
// bypass, RAW/WAW stalls, same-register issue+writeback, flush, async reset.
module tb_regfile_scoreboard;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [4:0]  RA1 = '0, RA2 = '0, WA = '0, ISSUE_RD = '0;
    logic [31:0] RD1, RD2, WD = '0;
    logic        WE = 1'b0, ISSUE_VALID = 1'b0, FLUSH = 1'b0;
    logic        ISSUE_READY, BUSY1, BUSY2;
    logic [5:0]  PEND_CNT;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard dut (
        .CLK(CLK), .RST(RST),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .WE(WE), .WA(WA), .WD(WD),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .FLUSH(FLUSH), .PEND_CNT(PEND_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE = 0; ISSUE_VALID = 0; FLUSH = 0; RA1 = 0; RA2 = 0;
    endtask

    task automatic test_reset();
        RST = 0;
        repeat (2) tick();
        RST = 1;
        RA1 = 5; RA2 = 0;
        #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got=%h exp=0", RD1); end
        checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got=%h exp=0", RD2); end
        checks++; if ({BUSY1, BUSY2} !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", {BUSY1, BUSY2}); end
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ISSUE_READY); end
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", PEND_CNT); end
    endtask

    task automatic test_write_x0();
        WE = 1; WA = 3; WD = 32'hDEADBEEF; tick();
        WA = 0; WD = 32'h1234; RA2 = 0;
        #1;
        checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL x0_no_bypass got=%h exp=0", RD2); end
        tick();
        WE = 0; RA1 = 3; RA2 = 0;
        #1;
        checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rd1 got=%h exp=deadbeef", RD1); end
        checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL x0_rd2 got=%h exp=0", RD2); end
        // Writing a non-pending register leaves the count alone.
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL write_cnt got=%0d exp=0", PEND_CNT); end
        idle();
    endtask

    task automatic test_bypass();
        WE = 1; WA = 7; WD = 32'h11; tick();
        WE = 0; ISSUE_VALID = 1; ISSUE_RD = 7; tick();
        ISSUE_VALID = 0; RA1 = 7;
        #1;
        checks++; if (PEND_CNT !== 6'd1) begin errors++; $display("FAIL byp_cnt_pre got=%0d exp=1", PEND_CNT); end
        checks++; if (BUSY1 !== 1'b1 || RD1 !== 32'h11) begin errors++; $display("FAIL byp_pre got=%b/%h exp=1/11", BUSY1, RD1); end
        WE = 1; WA = 7; WD = 32'h22;
        #1;
        checks++; if (RD1 !== 32'h22) begin errors++; $display("FAIL byp_rd1 got=%h exp=22", RD1); end
        checks++; if (BUSY1 !== 1'b0) begin errors++; $display("FAIL byp_busy got=%b exp=0", BUSY1); end
        tick();
        WE = 0;
        #1;
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL byp_cnt got=%0d exp=0", PEND_CNT); end
        checks++; if (BUSY1 !== 1'b0 || RD1 !== 32'h22) begin errors++; $display("FAIL byp_post got=%b/%h exp=0/22", BUSY1, RD1); end
        idle();
    endtask

    task automatic test_raw_stall();
        ISSUE_VALID = 1; ISSUE_RD = 4;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL raw_issue4 got=%b exp=1", ISSUE_READY); end
        tick();
        checks++; if (PEND_CNT !== 6'd1) begin errors++; $display("FAIL raw_cnt1 got=%0d exp=1", PEND_CNT); end
        RA2 = 4; ISSUE_RD = 5;
        #1;
        checks++; if (BUSY2 !== 1'b1 || ISSUE_READY !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b/%b exp=1/0", BUSY2, ISSUE_READY); end
        tick();
        checks++; if (PEND_CNT !== 6'd1) begin errors++; $display("FAIL raw_cnt_hold got=%0d exp=1", PEND_CNT); end
        WE = 1; WA = 4; WD = 32'h44;
        #1;
        checks++; if (ISSUE_READY !== 1'b1 || BUSY2 !== 1'b0) begin errors++; $display("FAIL raw_release got=%b/%b exp=1/0", ISSUE_READY, BUSY2); end
        tick();
        // Issue of 5 and clear of 4 in one edge: net zero.
        WE = 0; ISSUE_VALID = 0; RA1 = 5;
        #1;
        checks++; if (PEND_CNT !== 6'd1) begin errors++; $display("FAIL raw_net0 got=%0d exp=1", PEND_CNT); end
        checks++; if (BUSY1 !== 1'b1 || BUSY2 !== 1'b0) begin errors++; $display("FAIL raw_busy got=%b%b exp=10", BUSY1, BUSY2); end
        WE = 1; WA = 5; WD = 32'h55; tick();
        idle();
        #1;
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL raw_cnt0 got=%0d exp=0", PEND_CNT); end
    endtask

    task automatic test_same_reg();
        ISSUE_VALID = 1; ISSUE_RD = 9; tick();
        // Second writer to 9 with no writeback: WAW stall.
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL waw_stall got=%b exp=0", ISSUE_READY); end
        WE = 1; WA = 9; WD = 32'h99;
        #1;
        checks++; if (ISSUE_READY !== 1'b1) begin errors++; $display("FAIL same_ready got=%b exp=1", ISSUE_READY); end
        tick();
        idle(); RA1 = 9;
        #1;
        checks++; if (PEND_CNT !== 6'd1) begin errors++; $display("FAIL same_cnt got=%0d exp=1", PEND_CNT); end
        checks++; if (BUSY1 !== 1'b1 || RD1 !== 32'h99) begin errors++; $display("FAIL same_state got=%b/%h exp=1/99", BUSY1, RD1); end
        WE = 1; WA = 9; WD = 32'h9A; tick();
        idle();
        // Issue to x0 is accepted but never marks pending.
        ISSUE_VALID = 1; ISSUE_RD = 0; tick();
        ISSUE_VALID = 0;
        #1;
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL x0_issue_cnt got=%0d exp=0", PEND_CNT); end
    endtask

    task automatic test_flush_reset();
        ISSUE_VALID = 1;
        ISSUE_RD = 1; tick();
        ISSUE_RD = 2; tick();
        ISSUE_RD = 3; tick();
        ISSUE_VALID = 0;
        #1;
        checks++; if (PEND_CNT !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got=%0d exp=3", PEND_CNT); end
        FLUSH = 1; WE = 1; WA = 2; WD = 32'h55; ISSUE_VALID = 1; ISSUE_RD = 6;
        #1;
        checks++; if (ISSUE_READY !== 1'b0) begin errors++; $display("FAIL flush_block got=%b exp=0", ISSUE_READY); end
        tick();
        idle(); RA1 = 2; RA2 = 6;
        #1;
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL flush_cnt got=%0d exp=0", PEND_CNT); end
        checks++; if (RD1 !== 32'h55 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin errors++; $display("FAIL flush_state got=%h/%b%b exp=55/00", RD1, BUSY1, BUSY2); end
        ISSUE_VALID = 1; ISSUE_RD = 8; tick();
        ISSUE_VALID = 0;
        #2;
        RST = 0;
        #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL areset_rd got=%h exp=0", RD1); end
        checks++; if (PEND_CNT !== 6'd0) begin errors++; $display("FAIL areset_cnt got=%0d exp=0", PEND_CNT); end
        RST = 1;
    endtask

    initial begin
        test_reset();
        test_write_x0();
        test_bypass();
        test_raw_stall();
        test_same_reg();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the core's integer register file, built for the pipelined core. It keeps the 2-read/1-write storage and adds a hard-wired zero register and write-to-read bypass. It also adds a per-register pending scoreboard: the decode stage marks destination registers busy at issue, and writeback clears them. The block reports operand hazards and an issue-ready signal, and sits between decode/issue and writeback.

Parameters:
ADDR_WIDTH, 5, register address width.
DATA_WIDTH, 32, register data width.
DEPTH, 32, number of registers (<= 2**ADDR_WIDTH).
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending.
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active low
RA1  in  ADDR_WIDTH  read address port 1
RA2  in  ADDR_WIDTH  read address port 2
RD1  out  DATA_WIDTH  read data port 1 (combinational)
RD2  out  DATA_WIDTH  read data port 2 (combinational)
WE  in  1  writeback enable
WA  in  ADDR_WIDTH  writeback address
WD  in  DATA_WIDTH  writeback data
ISSUE_VALID  in  1  decode requests issue of an instruction
ISSUE_RD  in  ADDR_WIDTH  destination of the issuing instruction
ISSUE_READY  out  1  issue accepted this cycle if ISSUE_VALID
BUSY1  out  1  RA1 has an outstanding unresolved writer
BUSY2  out  1  RA2 has an outstanding unresolved writer
FLUSH  in  1  pipeline flush: clear all pending state
PEND_CNT  out  ADDR_WIDTH+1  number of pending registers

Behaviour:
- Reset (RST low, asynchronous): all registers = 0, all pending bits = 0, PEND_CNT = 0. Consequently BUSY1/BUSY2 = 0 and ISSUE_READY = 1. Reset asserted mid-operation discards all state immediately.
- Reads are combinational: RDn = reg[RAn].
  - If ZERO_REG and RAn == 0, RDn = 0.
  - If RAn >= DEPTH, RDn = 0.
  - If BYPASS, WE=1, WA == RAn, and WA is writable, RDn = WD in the same cycle.
- Write: on a rising edge with WE=1, reg[WA] <= WD. The write is ignored for WA >= DEPTH, and for WA == 0 when ZERO_REG=1.
- Writeback hit on a pending register:
  - WE=1 to a pending register clears its pending bit at the edge.
  - WE=1 to a non-pending register writes data only; pending state and count are unchanged.
- Hazard outputs: BUSYn = pending[RAn] AND NOT (BYPASS AND WE AND WA == RAn). With BYPASS=0, a register being written back this cycle still reports busy.
- ISSUE_READY = NOT BUSY1 AND NOT BUSY2 AND NOT wawhaz AND NOT FLUSH.
  - wawhaz = pending[ISSUE_RD] AND NOT (WE AND WA == ISSUE_RD).
  - RA1/RA2 are the source registers of the issuing instruction.
- Accepted issue = ISSUE_VALID AND ISSUE_READY. It sets pending[ISSUE_RD] at the edge, unless ISSUE_RD == 0 with ZERO_REG=1, or ISSUE_RD >= DEPTH.
- Simultaneous issue and writeback to the same register: the pending bit ends at 1 (new writer wins) and PEND_CNT is unchanged.
- PEND_CNT is registered:
  - +1 on an accepted issue that sets a previously clear bit.
  - -1 on a writeback that clears a set bit.
  - Both in the same cycle on different registers: net 0.
  - PEND_CNT always equals the popcount of the pending bits. It never wraps; maximum is DEPTH.
- FLUSH=1 at an edge: all pending bits cleared and PEND_CNT <= 0. A concurrent writeback still writes data. Issue is blocked that cycle.
- No internal clock gating and no multicycle paths. The only state is the register array, the pending vector and PEND_CNT.

Test Plan:
- Reset then read: RST low, then high; RA1=5, RA2=0 -> RD1=0, RD2=0, BUSY1=BUSY2=0, ISSUE_READY=1, PEND_CNT=0.
- Write/read and x0: WE=1, WA=3, WD=0xDEADBEEF, then WE=1, WA=0, WD=0x1234; read RA1=3, RA2=0 -> RD1=0xDEADBEEF, RD2=0.
- Bypass: reg 7 holds 0x11 and is pending. Drive WE=1, WA=7, WD=0x22, RA1=7 in the same cycle -> RD1=0x22, BUSY1=0. After the edge: pending[7]=0, PEND_CNT decremented by 1.
- RAW stall: issue ISSUE_RD=4 (accepted, PEND_CNT=1). Next cycle RA2=4, ISSUE_VALID=1 -> BUSY2=1, ISSUE_READY=0, PEND_CNT stays 1. Writeback to 4 -> ISSUE_READY=1 in that same cycle.
- Same-register issue and writeback: pending[9]=1, PEND_CNT=1. Drive WE=1, WA=9 with an accepted issue of ISSUE_RD=9 -> pending[9]=1, PEND_CNT=1, reg[9]=WD.
- Flush and async reset: issue regs 1, 2, 3 (PEND_CNT=3); FLUSH=1 with WE=1, WA=2, WD=0x55 -> PEND_CNT=0, reg[2]=0x55. Then drop RST mid-cycle -> reg[2] reads 0 immediately, no clock needed.
